// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared types and defaults for the safe front end and safe FSM
package safe_pkg;

  localparam int BTN_W                = 4;
  localparam int DEFAULT_MAX_FAILS    = 3;
  localparam int DEFAULT_LOCK_SECONDS = 10;

  typedef enum logic [1:0] {
    ARMED        = 2'd0,
    LOCKED       = 2'd1,
    RELEASE_WAIT = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - prescaler emitting a 1-cycle tick every TICK_CYCLES enabled cycles
module sec_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/safe_lockout_ctrl.sv
// rtl/safe_lockout_ctrl.sv - button press detect, failure counting and timed input lockout
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int LOCK_SECONDS = DEFAULT_LOCK_SECONDS,
  parameter int MAX_FAILS    = DEFAULT_MAX_FAILS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [BTN_W-1:0]                  btn_in,
  input  logic                              fail_pulse,
  input  logic                              unlock_pulse,
  output logic [BTN_W-1:0]                  btn_out,
  output logic                              locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
  output logic [$clog2(LOCK_SECONDS+1)-1:0] secs_left
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int SW = $clog2(LOCK_SECONDS + 1);

  lock_state_t      state_q, state_d;
  logic [BTN_W-1:0] btn_prev_q;
  logic [BTN_W-1:0] btn_out_q, btn_out_d;
  logic             locked_q;
  logic [FW-1:0]    fail_q, fail_d, fail_inc;
  logic [SW-1:0]    secs_q, secs_d;
  logic             press;
  logic             tick;

  // Only an idle-to-pressed transition counts; sliding between buttons does not.
  assign press    = (btn_prev_q == '0) && (btn_in != '0);
  assign fail_inc = fail_q + FW'(1);

  sec_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != LOCKED),
    .en_i  (state_q == LOCKED),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    fail_d    = fail_q;
    secs_d    = secs_q;
    btn_out_d = '0;
    case (state_q)
      ARMED: begin
        if (press) btn_out_d = btn_in;
        if (unlock_pulse) begin
          fail_d = '0;
        end else if (fail_pulse) begin
          if (fail_inc == FW'(MAX_FAILS)) begin
            state_d = LOCKED;
            fail_d  = '0;
            secs_d  = SW'(LOCK_SECONDS);
          end else begin
            fail_d = fail_inc;
          end
        end
      end
      LOCKED: begin
        if (tick) begin
          secs_d = secs_q - SW'(1);
          if (secs_q == SW'(1)) state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        // A button still held at expiry must be released before re-arming.
        if (btn_in == '0) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARMED;
      btn_prev_q <= '1;
      btn_out_q  <= '0;
      locked_q   <= 1'b0;
      fail_q     <= '0;
      secs_q     <= '0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_in;
      btn_out_q  <= btn_out_d;
      locked_q   <= (state_d != ARMED);
      fail_q     <= fail_d;
      secs_q     <= secs_d;
    end
  end

  assign btn_out    = btn_out_q;
  assign locked_out = locked_q;
  assign fail_count = fail_q;
  assign secs_left  = secs_q;

endmodule

// File: tb/tb_safe_lockout_ctrl.sv
// tb/tb_safe_lockout_ctrl.sv - scoreboard bench for safe_lockout_ctrl
module tb_safe_lockout_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic       fail_pulse;
  logic       unlock_pulse;
  logic [3:0] btn_out;
  logic       locked_out;
  logic [1:0] fail_count;
  logic [1:0] secs_left;

  typedef struct packed {
    logic       lk;
    logic [1:0] fc;
    logic [1:0] sl;
  } status_t;

  logic [3:0] exp_btn_q[$];
  status_t    exp_st_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  status_t    prev_st;
  status_t    cur_st;

  always #5 clk = ~clk;

  safe_lockout_ctrl #(
    .TICK_CYCLES (4),
    .LOCK_SECONDS(3),
    .MAX_FAILS   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .fail_pulse  (fail_pulse),
    .unlock_pulse(unlock_pulse),
    .btn_out     (btn_out),
    .locked_out  (locked_out),
    .fail_count  (fail_count),
    .secs_left   (secs_left)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic lk, input logic [1:0] fc, input logic [1:0] sl);
    status_t s;
    s.lk = lk;
    s.fc = fc;
    s.sl = sl;
    exp_st_q.push_back(s);
  endtask

  task automatic pulse(input logic f, input logic u);
    step();
    fail_pulse   = f;
    unlock_pulse = u;
    step();
    fail_pulse   = 1'b0;
    unlock_pulse = 1'b0;
  endtask

  task automatic lock_measure(input logic [3:0] pv, input int p_at, input int r_at,
                              input int exp_hi);
    int hi = 0;
    int nz = 0;
    push_st(1'b1, 2'd0, 2'd3);
    push_st(1'b1, 2'd0, 2'd2);
    push_st(1'b1, 2'd0, 2'd1);
    push_st(1'b1, 2'd0, 2'd0);
    push_st(1'b0, 2'd0, 2'd0);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!locked_out) break;
      hi++;
      if (secs_left != 2'd0) nz++;
      if (i == p_at) btn_in = pv;
      if (i == r_at) btn_in = 4'b0000;
    end
    check("lock_high_cycles", hi, exp_hi);
    check("lock_secs_nonzero_cycles", nz, 12);
  endtask

  // Monitor: pops expectations whenever a press event or status change appears.
  initial begin
    prev_st = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (btn_out != 4'b0000) begin
          if (exp_btn_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL btn_out_unexpected actual=%b required=none", btn_out);
          end else begin
            check("btn_out_event", int'(btn_out), int'(exp_btn_q.pop_front()));
          end
        end
        cur_st = {locked_out, fail_count, secs_left};
        if (cur_st != prev_st) begin
          if (exp_st_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL status_unexpected actual=%b required=%b", cur_st, prev_st);
          end else begin
            check("status_change", int'(cur_st), int'(exp_st_q.pop_front()));
          end
          prev_st = cur_st;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    btn_in       = 4'b0111;
    fail_pulse   = 1'b0;
    unlock_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_btn_out", btn_out, 0);
    check("reset_locked_out", locked_out, 0);
    check("reset_fail_count", fail_count, 0);
    check("reset_secs_left", secs_left, 0);
    mon_en = 1'b1;

    // 1: button held through reset gives no event; fresh press gives one
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("held_through_reset", btn_out, 0);
    step();
    btn_in = 4'b0000;
    repeat (2) step();
    exp_btn_q.push_back(4'b0111);
    btn_in = 4'b0111;
    @(negedge clk);
    check("press_not_yet", btn_out, 0);
    @(negedge clk);
    check("press_event", btn_out, 4'b0111);
    @(negedge clk);
    check("press_one_cycle", btn_out, 0);
    step();
    btn_in = 4'b0000;
    repeat (2) step();

    // 2: long hold and nonzero-to-nonzero step give one event
    exp_btn_q.push_back(4'b1101);
    btn_in = 4'b1101;
    repeat (20) step();
    btn_in = 4'b0101;
    repeat (5) step();
    btn_in = 4'b0000;
    repeat (3) step();

    // 3: three fails lock; presses during lockout are blocked
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    lock_measure(4'b0100, 2, 5, 13);
    repeat (3) step();

    // 4: unlock clears count; unlock wins over a simultaneous fail
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd0, 2'd0);
    pulse(1'b0, 1'b1);
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd0, 2'd0);
    pulse(1'b1, 1'b1);
    repeat (3) step();
    @(negedge clk);
    check("fail_unlock_no_lock", locked_out, 0);
    check("fail_unlock_count", fail_count, 0);

    // 5: button held past expiry keeps input blocked until released
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    lock_measure(4'b0001, 2, 15, 16);
    repeat (3) step();

    // 6: reset mid-lockout, then a full relock
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b1, 2'd0, 2'd3);
    push_st(1'b1, 2'd0, 2'd2);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (secs_left == 2'd2) break;
    end
    check("reach_secs_2", secs_left, 2);
    push_st(1'b0, 2'd0, 2'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midlock_rst_locked", locked_out, 0);
    check("midlock_rst_secs", secs_left, 0);
    check("midlock_rst_fails", fail_count, 0);
    rst = 1'b0;
    step();
    push_st(1'b0, 2'd1, 2'd0);
    pulse(1'b1, 1'b0);
    push_st(1'b0, 2'd2, 2'd0);
    pulse(1'b1, 1'b0);
    lock_measure(4'b0000, -1, -1, 13);

    repeat (3) step();
    @(negedge clk);
    check("btn_queue_drained", exp_btn_q.size(), 0);
    check("status_queue_drained", exp_st_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
